// File: rtl/pipe_control_if.sv
// Bundles the ID-stage instruction inputs and the staged control outputs of pipe_control.
// The master side drives the instruction stream; the slave side is the control block.
interface pipe_control_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [31:0]        instr_i;
  logic               instr_valid_i;
  logic               flush_i;
  logic               branch_o;
  logic               illegal_o;
  logic               stall_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               wb_reg_write_o;
  logic               wb_mem_to_reg_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i, flush_i,
    input  branch_o, illegal_o, stall_o, ex_alu_op_o, ex_alu_src_o,
           mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i,
    output branch_o, illegal_o, stall_o, ex_alu_op_o, ex_alu_src_o,
           mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID-stage instruction, carries control bits through
// ID/EX, EX/MEM and MEM/WB, detects load-use hazards and counts stall cycles.
module pipe_control #(
  parameter int ALUOP_W    = 3,
  parameter bit ENABLE_MUL = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  pipe_control_if.slave bus
);
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b101;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memToReg;
  } exmem_t;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
  } memwb_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  idex_t            decoded;
  logic             legal;
  logic             isBeq;
  logic             usesRs2;
  logic             hazard;
  logic             stall;
  logic             bubble;
  idex_t            idEx_q, idEx_d;
  exmem_t           exMem_q, exMem_d;
  memwb_t           memWb_q, memWb_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];
  assign rs1    = bus.instr_i[19:15];
  assign rs2    = bus.instr_i[24:20];

  // Every path starts from an all-zero bubble, so unsupported encodings never reuse stale controls.
  always_comb begin
    decoded    = '0;
    decoded.rd = bus.instr_i[11:7];
    legal      = 1'b0;
    isBeq      = 1'b0;
    usesRs2    = 1'b0;
    case (opcode)
      7'b0110011: begin
        usesRs2          = 1'b1;
        decoded.regWrite = 1'b1;
        legal            = 1'b1;
        if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          decoded.aluOp = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          decoded.aluOp = OP_SRA;
        end else if (ENABLE_MUL && funct7 == 7'b0000001 && funct3 == 3'b000) begin
          decoded.aluOp = OP_MUL;
        end else if (funct7 == 7'b0000000 && funct3 != 3'b010 && funct3 != 3'b011) begin
          decoded.aluOp = funct3;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0010011: begin
        decoded.aluSrc   = 1'b1;
        decoded.regWrite = 1'b1;
        case (funct3)
          3'b000, 3'b100, 3'b110, 3'b111: begin
            legal         = 1'b1;
            decoded.aluOp = funct3;
          end
          3'b001: begin
            legal         = 1'b1;
            decoded.aluOp = OP_SLL;
          end
          3'b101: begin
            legal         = (funct7 == 7'b0100000);
            decoded.aluOp = OP_SRA;
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        legal            = (funct3 == 3'b010);
        decoded.aluSrc   = 1'b1;
        decoded.regWrite = 1'b1;
        decoded.memToReg = 1'b1;
        decoded.memRead  = 1'b1;
      end
      7'b0100011: begin
        usesRs2          = 1'b1;
        legal            = (funct3 == 3'b010);
        decoded.aluSrc   = 1'b1;
        decoded.memWrite = 1'b1;
      end
      7'b1100011: begin
        usesRs2       = 1'b1;
        legal         = (funct3 == 3'b000);
        isBeq         = legal;
        decoded.aluOp = OP_SUB;
      end
      default: legal = 1'b0;
    endcase
    if (!legal || !bus.instr_valid_i) begin
      decoded = '0;
      isBeq   = 1'b0;
    end
  end

  // A flush outranks a stall: the killed instruction must not hold the front end.
  always_comb begin
    hazard = idEx_q.memRead && (idEx_q.rd != 5'd0) && bus.instr_valid_i &&
             ((idEx_q.rd == rs1) || (usesRs2 && (idEx_q.rd == rs2)));
    stall  = hazard && !bus.flush_i;
    bubble = stall || bus.flush_i || !bus.instr_valid_i;
    idEx_d = bubble ? '0 : decoded;
    exMem_d = '{memRead:  idEx_q.memRead,  memWrite: idEx_q.memWrite,
                regWrite: idEx_q.regWrite, memToReg: idEx_q.memToReg};
    memWb_d = '{regWrite: exMem_q.regWrite, memToReg: exMem_q.memToReg};
    stallCnt_d = (stall && (stallCnt_q != '1)) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idEx_q     <= '0;
      exMem_q    <= '0;
      memWb_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      idEx_q     <= idEx_d;
      exMem_q    <= exMem_d;
      memWb_q    <= memWb_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.branch_o        = isBeq;
  assign bus.illegal_o       = bus.instr_valid_i && !legal && !bus.flush_i;
  assign bus.stall_o         = stall;
  assign bus.ex_alu_op_o     = ALUOP_W'(idEx_q.aluOp);
  assign bus.ex_alu_src_o    = idEx_q.aluSrc;
  assign bus.mem_read_o      = exMem_q.memRead;
  assign bus.mem_write_o     = exMem_q.memWrite;
  assign bus.wb_reg_write_o  = memWb_q.regWrite;
  assign bus.wb_mem_to_reg_o = memWb_q.memToReg;
  assign bus.stall_cnt_o     = stallCnt_q;
endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: a default instance plus a second instance with
// ENABLE_MUL=0 and CNT_W=2 fed the same instruction stream.
module tb_pipe_control;
  // Expected control word layout: [7:5] aluOp, [4] aluSrc, [3] memRead, [2] memWrite, [1] regWrite, [0] memToReg
  localparam logic [7:0] BUB  = 8'h00;
  localparam logic [7:0] ADDR = 8'h02;
  localparam logic [7:0] SUBR = 8'h42;
  localparam logic [7:0] MULR = 8'h62;
  localparam logic [7:0] SWC  = 8'h14;
  localparam logic [7:0] LWC  = 8'h1B;
  localparam logic [7:0] BEQC = 8'h40;
  localparam logic [7:0] XORI = 8'h92;
  localparam logic [7:0] SRAI = 8'hB2;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_USE   = 32'h00128333;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_SLT   = 32'h0020A1B3;
  localparam logic [31:0] I_XORI  = 32'h0040C093;
  localparam logic [31:0] I_SRAI  = 32'h4010D093;
  localparam logic [31:0] I_LWDEP = 32'h0002A283;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   expCnt = 0;
  int   expCntSmall = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  pipe_control_if #(.ALUOP_W(3), .CNT_W(16)) bus ();
  pipe_control_if #(.ALUOP_W(3), .CNT_W(2))  bus2 ();

  pipe_control #(.ALUOP_W(3), .ENABLE_MUL(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  pipe_control #(.ALUOP_W(3), .ENABLE_MUL(1'b0), .CNT_W(2)) dutSmall (
    .clk_i(clk), .rst_i(rst), .bus(bus2.slave)
  );

  assign bus2.instr_i       = bus.instr_i;
  assign bus2.instr_valid_i = bus.instr_valid_i;
  assign bus2.flush_i       = bus.flush_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic flush,
                               input logic [7:0] expEx, input logic expStall,
                               input logic expIllegal, input logic expBranch);
    bus.instr_i       = instr;
    bus.instr_valid_i = valid;
    bus.flush_i       = flush;
    #1;
    checkOutput("stall_o", 32'(bus.stall_o), 32'(expStall));
    checkOutput("illegal_o", 32'(bus.illegal_o), 32'(expIllegal));
    checkOutput("branch_o", 32'(bus.branch_o), 32'(expBranch));
    expQ.push_back(expEx);
    if (expStall) begin
      expCnt++;
      if (expCntSmall < 3) expCntSmall++;
    end
  endtask

  // Each edge retires the oldest queued word from WB; the two younger ones sit in MEM and EX.
  task automatic stepClock();
    logic [7:0] exW, memW, wbW;
    @(posedge clk);
    #1;
    if (expQ.size() != 3) begin
      $display("[TB] FAIL scoreboard_depth: got %0d, expected 3", expQ.size());
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] scoreboard out of step");
    end
    exW  = expQ[2];
    memW = expQ[1];
    wbW  = expQ[0];
    checkOutput("ex_alu_op", 32'(bus.ex_alu_op_o), 32'(exW[7:5]));
    checkOutput("ex_alu_src", 32'(bus.ex_alu_src_o), 32'(exW[4]));
    checkOutput("mem_read", 32'(bus.mem_read_o), 32'(memW[3]));
    checkOutput("mem_write", 32'(bus.mem_write_o), 32'(memW[2]));
    checkOutput("wb_reg_write", 32'(bus.wb_reg_write_o), 32'(wbW[1]));
    checkOutput("wb_mem_to_reg", 32'(bus.wb_mem_to_reg_o), 32'(wbW[0]));
    checkOutput("stall_cnt", 32'(bus.stall_cnt_o), 32'(expCnt));
    checkOutput("stall_cnt_small", 32'(bus2.stall_cnt_o), 32'(expCntSmall));
    void'(expQ.pop_front());
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_ex_alu_op", 32'(bus.ex_alu_op_o), 32'd0);
    checkOutput("rst_mem_read", 32'(bus.mem_read_o), 32'd0);
    checkOutput("rst_mem_write", 32'(bus.mem_write_o), 32'd0);
    checkOutput("rst_wb_reg_write", 32'(bus.wb_reg_write_o), 32'd0);
    checkOutput("rst_wb_mem_to_reg", 32'(bus.wb_mem_to_reg_o), 32'd0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    checkOutput("rst_stall_o", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    expQ.push_back(BUB);
    expQ.push_back(BUB);
    expCnt      = 0;
    expCntSmall = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, BUB, 1'b0, 1'b0, 1'b0);
      stepClock();
    end
  endtask

  initial begin
    bus.instr_i       = 32'h0;
    bus.instr_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    #2;
    doReset();

    // Single add through all stages
    applyStimulus(I_ADD, 1'b1, 1'b0, ADDR, 1'b0, 1'b0, 1'b0);
    stepClock();
    drain();

    // sub, mul, sw back to back; the MUL-less instance rejects the mul
    applyStimulus(I_SUB, 1'b1, 1'b0, SUBR, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_MUL, 1'b1, 1'b0, MULR, 1'b0, 1'b0, 1'b0);
    checkOutput("small_illegal_mul", 32'(bus2.illegal_o), 32'd1);
    stepClock();
    checkOutput("small_ex_alu_op_mul", 32'(bus2.ex_alu_op_o), 32'd0);
    applyStimulus(I_SW, 1'b1, 1'b0, SWC, 1'b0, 1'b0, 1'b0);
    stepClock();
    drain();

    // Load-use stall
    applyStimulus(I_LW, 1'b1, 1'b0, LWC, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_USE, 1'b1, 1'b0, BUB, 1'b1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_USE, 1'b1, 1'b0, ADDR, 1'b0, 1'b0, 1'b0);
    stepClock();
    drain();

    // Load-use with flush in the hazard cycle, then beq
    applyStimulus(I_LW, 1'b1, 1'b0, LWC, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_USE, 1'b1, 1'b1, BUB, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_USE, 1'b1, 1'b0, ADDR, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_BEQ, 1'b1, 1'b0, BEQC, 1'b0, 1'b0, 1'b1);
    stepClock();
    drain();

    // Illegal and invalid encodings, I-type forms
    applyStimulus(I_BAD, 1'b1, 1'b0, BUB, 1'b0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(I_ADD, 1'b0, 1'b0, BUB, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_SLT, 1'b1, 1'b0, BUB, 1'b0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(I_XORI, 1'b1, 1'b0, XORI, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_SRAI, 1'b1, 1'b0, SRAI, 1'b0, 1'b0, 1'b0);
    stepClock();

    // Chain of dependent loads forces five stalls; the 2-bit counter saturates
    applyStimulus(I_LW, 1'b1, 1'b0, LWC, 1'b0, 1'b0, 1'b0);
    stepClock();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(I_LWDEP, 1'b1, 1'b0, BUB, 1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(I_LWDEP, 1'b1, 1'b0, LWC, 1'b0, 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("small_cnt_saturated", 32'(bus2.stall_cnt_o), 32'd3);
    drain();

    // Reset mid-stream with lw in MEM and add in EX
    applyStimulus(I_LW, 1'b1, 1'b0, LWC, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(I_ADD, 1'b1, 1'b0, ADDR, 1'b0, 1'b0, 1'b0);
    stepClock();
    #2;
    doReset();
    applyStimulus(I_ADD, 1'b1, 1'b0, ADDR, 1'b0, 1'b0, 1'b0);
    stepClock();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
